// File: rtl/insn_fetch.sv
// Instruction fetch unit: drives a synchronous instruction memory and hands {insn, pc} to decode via valid/ready.
// Optional FETCH_PERF_EN adds saturating handshake/stall counters (perf_fetched, perf_stalls).
module insn_fetch #(
  parameter int              ADDR_W   = 10,
  parameter int              INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [INSN_W-1:0] insn_in,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [INSN_W-1:0] fetch_insn,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalls
`endif
);

  logic [ADDR_W-1:0] pc_q;
  logic              f2_valid;
  logic [ADDR_W-1:0] f2_pc;
  logic              can_take;

  assign can_take = !fetch_valid || fetch_ready;

  // During a stall the held address is re-read so insn_in still matches f2_pc next cycle.
  always_comb begin
    pc_out = pc_q;
    if (!rst_n)
      pc_out = RESET_PC;
    else if (redirect_valid)
      pc_out = redirect_pc;
    else if (!can_take)
      pc_out = f2_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      f2_valid    <= 1'b0;
      f2_pc       <= '0;
      fetch_valid <= 1'b0;
      fetch_insn  <= '0;
      fetch_pc    <= '0;
    end else if (redirect_valid) begin
      f2_valid    <= 1'b1;
      f2_pc       <= redirect_pc;
      pc_q        <= redirect_pc + 1'b1;
      fetch_valid <= 1'b0;
    end else if (can_take) begin
      fetch_valid <= f2_valid;
      fetch_insn  <= insn_in;
      fetch_pc    <= f2_pc;
      if (fetch_en) begin
        f2_valid <= 1'b1;
        f2_pc    <= pc_q;
        pc_q     <= pc_q + 1'b1;
      end else begin
        f2_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (fetch_valid && fetch_ready && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (fetch_valid && !fetch_ready && (perf_stalls != 32'hFFFF_FFFF))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
